// File: rtl/keyboard_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes and turns make/break codes for
// Enter, Up, Down and Esc into a level-held 4-bit key vector with a change pulse.
module keyboard_key_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 65000,
  parameter logic [7:0]  SC_ENTER       = 8'h5A,
  parameter logic [7:0]  SC_UP          = 8'h75,
  parameter logic [7:0]  SC_DOWN        = 8'h72,
  parameter logic [7:0]  SC_ESC         = 8'h76
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] keyboard_out,
  output logic       key_event
);

  localparam int unsigned      CNT_W    = $clog2(PREFIX_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [7:0]       SC_EXT   = 8'hE0;
  localparam logic [7:0]       SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       keys_q, keys_d;
  logic             event_q, event_d;
  logic [3:0]       mask_s;
  logic             ext_s;
  logic             brk_s;

  // Keyboard self-test / error / overrun bytes: they drop all held keys and any prefix.
  function automatic logic is_flush(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // Keypad 75/72 share codes with the arrows, so arrows only count with the E0 prefix.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    logic [3:0] m;
    m = 4'b0000;
    if (ext) begin
      if (code == SC_ENTER) begin
        m = 4'b0001;
      end else if (code == SC_UP) begin
        m = 4'b0010;
      end else if (code == SC_DOWN) begin
        m = 4'b0100;
      end else begin
        m = 4'b0000;
      end
    end else begin
      if (code == SC_ENTER) begin
        m = 4'b0001;
      end else if (code == SC_ESC) begin
        m = 4'b1000;
      end else begin
        m = 4'b0000;
      end
    end
    return m;
  endfunction

  assign ext_s = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign brk_s = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

  // Next-state, prefix timeout and key-vector update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    keys_d  = keys_q;
    mask_s  = 4'b0000;
    if (rx_valid) begin
      cnt_d = '0;
      if (is_flush(rx_data)) begin
        keys_d  = 4'b0000;
        state_d = ST_IDLE;
      end else if (rx_data == SC_EXT) begin
        case (state_q)
          ST_IDLE:    state_d = ST_EXT;
          ST_EXT:     state_d = ST_EXT;
          ST_BRK:     state_d = ST_EXT_BRK;
          ST_EXT_BRK: state_d = ST_EXT_BRK;
          default:    state_d = ST_IDLE;
        endcase
      end else if (rx_data == SC_BRK) begin
        case (state_q)
          ST_IDLE:    state_d = ST_BRK;
          ST_EXT:     state_d = ST_EXT_BRK;
          ST_BRK:     state_d = ST_BRK;
          ST_EXT_BRK: state_d = ST_EXT_BRK;
          default:    state_d = ST_IDLE;
        endcase
      end else begin
        mask_s = key_mask(rx_data, ext_s);
        if (brk_s) begin
          keys_d = keys_q & ~mask_s;
        end else begin
          keys_d = keys_q | mask_s;
        end
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Stale prefix: drop the sequence but keep the held keys.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    event_d = (keys_d != keys_q);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      keys_q  <= 4'b0000;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
      event_q <= event_d;
    end
  end

  assign keyboard_out = keys_q;
  assign key_event    = event_q;

endmodule

// File: tb/tb_keyboard_key_decoder.sv
// Self-checking bench for keyboard_key_decoder: byte/expectation table plus
// hand-written timeout and reset-interruption sequences.
module tb_keyboard_key_decoder;

  localparam int unsigned TO = 16;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] keyboard_out;
  logic       key_event;

  int checks;
  int errors;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] o;
    logic       e;
  } vec_t;

  typedef struct {
    logic [3:0] o;
    logic       e;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  keyboard_key_decoder #(.PREFIX_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .keyboard_out (keyboard_out),
    .key_event    (key_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [7:0] d, input logic [3:0] o, input logic e);
    vec_t x;
    x.v = v; x.d = d; x.o = o; x.e = e;
    vecs.push_back(x);
  endtask

  // Drive one cycle from a negedge, push the expectation, compare at the next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] o, input logic e,
                      input string name);
    exp_t x;
    exp_t got;
    rx_valid = v;
    rx_data  = d;
    x.o = o; x.e = e;
    exp_q.push_back(x);
    @(negedge clk);
    rx_valid = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (keyboard_out !== got.o || key_event !== got.e) begin
      errors++;
      $display("FAIL %s: keyboard_out=%b key_event=%b, expected keyboard_out=%b key_event=%b",
               name, keyboard_out, key_event, got.o, got.e);
    end
  endtask

  task automatic idle(input int n, input logic [3:0] o, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, o, 1'b0, name);
  endtask

  task automatic do_reset(input int n, input string name);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    checks++;
    if (keyboard_out !== 4'b0000 || key_event !== 1'b0) begin
      errors++;
      $display("FAIL %s: keyboard_out=%b key_event=%b, expected keyboard_out=0000 key_event=0",
               name, keyboard_out, key_event);
    end
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Make / break / prefixes
    add(1, 8'h5A, 4'b0001, 1); add(0, 8'h00, 4'b0001, 0);
    add(1, 8'hF0, 4'b0001, 0); add(1, 8'h5A, 4'b0000, 1);
    add(1, 8'hE0, 4'b0000, 0); add(1, 8'h75, 4'b0010, 1);
    add(1, 8'hE0, 4'b0010, 0); add(1, 8'h72, 4'b0110, 1);
    add(1, 8'hE0, 4'b0110, 0); add(1, 8'hF0, 4'b0110, 0); add(1, 8'h75, 4'b0100, 1);
    add(1, 8'h75, 4'b0100, 0);
    add(1, 8'hE0, 4'b0100, 0); add(1, 8'hF0, 4'b0100, 0); add(1, 8'h72, 4'b0000, 1);
    // Typematic, Esc, flush
    add(1, 8'h5A, 4'b0001, 1);
    for (int i = 0; i < 4; i++) add(1, 8'h5A, 4'b0001, 0);
    add(1, 8'h76, 4'b1001, 1); add(1, 8'hAA, 4'b0000, 1); add(1, 8'hAA, 4'b0000, 0);
    // Ignored codes and redundant breaks
    add(1, 8'hE0, 4'b0000, 0); add(1, 8'h76, 4'b0000, 0);
    add(1, 8'hF0, 4'b0000, 0); add(1, 8'hF0, 4'b0000, 0); add(1, 8'h5A, 4'b0000, 0);
    add(1, 8'hE0, 4'b0000, 0); add(1, 8'h5A, 4'b0001, 1);
    add(1, 8'hE0, 4'b0001, 0); add(1, 8'hFF, 4'b0000, 1); add(1, 8'h75, 4'b0000, 0);
    add(1, 8'hE0, 4'b0000, 0); add(1, 8'hE0, 4'b0000, 0); add(1, 8'h72, 4'b0100, 1);
    add(1, 8'hF0, 4'b0100, 0); add(1, 8'hE0, 4'b0100, 0); add(1, 8'h72, 4'b0000, 1);
    add(1, 8'h5A, 4'b0001, 1); add(1, 8'h76, 4'b1001, 1);
    add(1, 8'hE0, 4'b1001, 0); add(1, 8'hF0, 4'b1001, 0);
    add(1, 8'hE0, 4'b1001, 0); add(1, 8'hF0, 4'b1001, 0); add(1, 8'h5A, 4'b1000, 1);
    add(1, 8'hFC, 4'b0000, 1);
    // rx_data ignored without rx_valid
    add(0, 8'hF0, 4'b0000, 0); add(1, 8'h5A, 4'b0001, 1);
    add(1, 8'hE0, 4'b0001, 0); add(1, 8'h5A, 4'b0001, 0);
    add(1, 8'hF0, 4'b0001, 0); add(1, 8'h00, 4'b0000, 1);
    // Back-to-back strobes
    add(1, 8'hE0, 4'b0000, 0); add(1, 8'h5A, 4'b0001, 1);
    add(1, 8'hF0, 4'b0001, 0); add(1, 8'h5A, 4'b0000, 1); add(0, 8'h00, 4'b0000, 0);

    do_reset(2, "reset");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].v, vecs[i].d, vecs[i].o, vecs[i].e, $sformatf("vec%0d", i));

    // EXT prefix expires after TO idle cycles; plain 75 is then ignored
    step(1'b1, 8'hE0, 4'b0000, 1'b0, "to_ext_e0");
    idle(TO, 4'b0000, "to_ext_idle");
    step(1'b1, 8'h75, 4'b0000, 1'b0, "to_ext_expired");
    // Byte on the last cycle before expiry still uses the prefix
    step(1'b1, 8'hE0, 4'b0000, 1'b0, "to_edge_e0");
    idle(TO - 1, 4'b0000, "to_edge_idle");
    step(1'b1, 8'h75, 4'b0010, 1'b1, "to_edge_hit");
    // EXT_BRK expiry keeps keys; late 75 is a plain make
    step(1'b1, 8'hE0, 4'b0010, 1'b0, "to_eb_e0");
    step(1'b1, 8'hF0, 4'b0010, 1'b0, "to_eb_f0");
    idle(TO, 4'b0010, "to_eb_idle");
    step(1'b1, 8'h75, 4'b0010, 1'b0, "to_eb_expired");
    step(1'b1, 8'hE0, 4'b0010, 1'b0, "to_eb2_e0");
    step(1'b1, 8'hF0, 4'b0010, 1'b0, "to_eb2_f0");
    idle(TO - 1, 4'b0010, "to_eb2_idle");
    step(1'b1, 8'h75, 4'b0000, 1'b1, "to_eb2_hit");

    // Reset in the middle of a prefixed sequence
    step(1'b1, 8'hE0, 4'b0000, 1'b0, "rst_e0");
    step(1'b1, 8'h75, 4'b0010, 1'b1, "rst_up");
    step(1'b1, 8'hE0, 4'b0010, 1'b0, "rst_e0b");
    do_reset(1, "rst_mid");
    step(1'b1, 8'h75, 4'b0000, 1'b0, "rst_after_75");
    step(1'b1, 8'hE0, 4'b0000, 1'b0, "rst2_e0");
    step(1'b1, 8'h75, 4'b0010, 1'b1, "rst2_up");
    step(1'b1, 8'hE0, 4'b0010, 1'b0, "rst2_e0b");
    do_reset(1, "rst2_mid");
    step(1'b1, 8'hF0, 4'b0000, 1'b0, "rst2_f0");
    step(1'b1, 8'h75, 4'b0000, 1'b0, "rst2_brk75");
    idle(2, 4'b0000, "tail_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
